pipeline_hazard_ctrl: RTL and testbench

- Central sequencing controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It drives write-enables and flushes for the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three hazards: load-use stalls, EX-stage redirects (taken branch, jal, jalr), and multi-cycle EX operations (divider) via a busy-wait FSM with watchdog.
- Keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencing controller for the 5-stage RV32I pipeline.
// Drives the PC, IF/ID, ID/EX and EX/MEM enables and flushes. It handles
// load-use stalls, EX-stage redirects and multi-cycle EX operations. A
// multi-cycle operation is held in a busy-wait FSM that has a watchdog.
// Two saturating counters track stall cycles and flush cycles.
module pipeline_hazard_ctrl #(
  parameter int MC_MAX_CYCLES = 64,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mc_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCNT_W = (MC_MAX_CYCLES > 1) ? $clog2(MC_MAX_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WD_LAST = WCNT_W'(MC_MAX_CYCLES - 1);

  typedef enum logic {RUN, MC_WAIT} state_t;

  typedef struct packed {
    logic pc_we;
    logic pc_sel;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_DEF = '{pc_we: 1'b1, pc_sel: 1'b0, if_id_we: 1'b1,
                                 if_id_flush: 1'b0, id_ex_we: 1'b1,
                                 id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

  state_t            state, state_nx;
  logic [WCNT_W-1:0] wcnt, wcnt_nx;
  ctrl_t             ctrl;
  logic              timeout;
  logic              rs1_hit, rs2_hit, load_use;

  // Load-use detection. x0 is never a real producer, so it cannot stall.
  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  // FSM state and the watchdog wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // Next state and the control outputs for this cycle. Everything stays at
  // its default while reset is asserted.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    ctrl     = CTRL_DEF;
    timeout  = 1'b0;
    if (rst) begin
      unique case (state)
        RUN: begin
          if (ex_redirect) begin
            // The instructions in IF and ID are on the wrong path, so any
            // hazard they raise does not matter.
            ctrl.pc_sel      = 1'b1;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (ex_mc_start && !mc_done) begin
            ctrl.pc_we        = 1'b0;
            ctrl.if_id_we     = 1'b0;
            ctrl.id_ex_we     = 1'b0;
            ctrl.ex_mem_flush = 1'b1;
            state_nx          = MC_WAIT;
            wcnt_nx           = '0;
          end else if (ex_mc_start) begin
            // The result is ready in one cycle, so it flows through unstalled.
          end else if (load_use) begin
            ctrl.pc_we       = 1'b0;
            ctrl.if_id_we    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state_nx = RUN;
          end else if (wcnt == WD_LAST) begin
            // Watchdog abort. The stall is released, but EX/MEM stays a
            // bubble so the unfinished result is dropped.
            timeout           = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
            state_nx          = RUN;
          end else begin
            ctrl.pc_we        = 1'b0;
            ctrl.if_id_we     = 1'b0;
            ctrl.id_ex_we     = 1'b0;
            ctrl.ex_mem_flush = 1'b1;
            wcnt_nx           = wcnt + 1'b1;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign pc_we        = ctrl.pc_we;
  assign pc_sel       = ctrl.pc_sel;
  assign if_id_we     = ctrl.if_id_we;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_we     = ctrl.id_ex_we;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign pc_target    = ex_target;
  assign mc_timeout   = timeout;
  // busy drops on the cycle the unit reports done, since that cycle does not stall.
  assign busy         = rst && (state == MC_WAIT) && !mc_done;

  // Saturating performance counters. A clear wins over an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (cnt_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!ctrl.pc_we && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (ctrl.if_id_flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. A vector table covers the RUN
// priorities, and hand-written sequences cover the multi-cycle behaviour.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int MCM   = 64;

  // Control bit order: {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush}
  localparam logic [6:0] DEF   = 7'b1010100;
  localparam logic [6:0] LU    = 7'b0000110;
  localparam logic [6:0] REDIR = 7'b1111110;
  localparam logic [6:0] MCST  = 7'b0000001;
  localparam logic [6:0] WDOG  = 7'b1010101;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, ex_mc_start, mc_done, cnt_clr;
  logic [31:0] ex_target, pc_target;
  logic pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush;
  logic mc_timeout, busy;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipeline_hazard_ctrl #(.MC_MAX_CYCLES(MCM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .ex_mc_start(ex_mc_start), .mc_done(mc_done), .cnt_clr(cnt_clr),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mc_timeout(mc_timeout), .busy(busy),
    .stall_count(stall_count), .flush_count(flush_count));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        mr, redir;
    logic [31:0] tgt;
    logic        mcs, mcd;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs[11];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mkv(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic [4:0] rd, logic mr, logic redir, logic [31:0] tgt,
                               logic mcs, logic mcd, logic [6:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.mr = mr;
    v.redir = redir; v.tgt = tgt; v.mcs = mcs; v.mcd = mcd; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] ctl();
    return {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0; ex_rd = '0;
    ex_mem_read = 0; ex_redirect = 0; ex_target = '0; ex_mc_start = 0; mc_done = 0;
    cnt_clr = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic load_use5();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1;
  endtask

  initial begin
    int st, fl, bz, sel, pulses, at;
    vecs[0]  = mkv(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 32'h0,   0, 0, DEF);   // no hazard
    vecs[1]  = mkv(5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 32'h0,   0, 0, LU);    // rs2 load-use
    vecs[2]  = mkv(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 32'h0,   0, 0, DEF);   // rd=x0
    vecs[3]  = mkv(5'd7, 5'd1, 1, 0, 5'd7, 1, 0, 32'h0,   0, 0, LU);    // rs1 load-use
    vecs[4]  = mkv(5'd7, 5'd1, 0, 0, 5'd7, 1, 0, 32'h0,   0, 0, DEF);   // rs1 not read
    vecs[5]  = mkv(5'd9, 5'd9, 1, 1, 5'd9, 1, 0, 32'h0,   0, 0, LU);    // both match
    vecs[6]  = mkv(5'd9, 5'd9, 1, 1, 5'd9, 0, 0, 32'h0,   0, 0, DEF);   // not a load
    vecs[7]  = mkv(5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 32'h100, 0, 0, REDIR); // redirect beats load-use
    vecs[8]  = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h44,  1, 1, DEF);   // 1-cycle mc op
    vecs[9]  = mkv(5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 32'h0,   1, 1, DEF);   // 1-cycle mc beats load-use
    vecs[10] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 32'hdead_bee0, 1, 0, REDIR); // redirect beats mc start

    // Reset: the outputs stay at their defaults even while hazard inputs are present.
    rst = 0; idle();
    ex_redirect = 1; ex_mc_start = 1; load_use5();
    #12;
    chk("rst_ctl", 32'(ctl()), 32'(DEF));
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(mc_timeout), 0);
    chk("rst_stall_cnt", 32'(stall_count), 0);
    chk("rst_flush_cnt", 32'(flush_count), 0);
    idle();
    @(negedge clk); rst = 1;

    // Table of single-cycle vectors in RUN.
    for (int i = 0; i < 11; i++) begin
      next();
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_uses_rs1 = vecs[i].u1;
      id_uses_rs2 = vecs[i].u2; ex_rd = vecs[i].rd; ex_mem_read = vecs[i].mr;
      ex_redirect = vecs[i].redir; ex_target = vecs[i].tgt;
      ex_mc_start = vecs[i].mcs; mc_done = vecs[i].mcd;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_target", i), pc_target, vecs[i].tgt);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 0);
    end

    // A single load-use cycle counts one stall. A redirect counts one flush
    // and no stall. A load with rd=x0 counts nothing.
    next(); idle(); cnt_clr = 1;
    next(); cnt_clr = 0; load_use5();
    @(negedge clk);
    chk("lu_ctl", 32'(ctl()), 32'(LU));
    next(); idle();
    chk("lu_stall_cnt", 32'(stall_count), 1);
    chk("lu_flush_cnt", 32'(flush_count), 0);
    load_use5(); ex_redirect = 1; ex_target = 32'h100;
    @(negedge clk);
    chk("redir_ctl", 32'(ctl()), 32'(REDIR));
    chk("redir_target", pc_target, 32'h100);
    next(); idle(); load_use5(); ex_rd = 5'd0; id_rs2 = 5'd0;
    @(negedge clk);
    chk("rd0_ctl", 32'(ctl()), 32'(DEF));
    next(); idle();
    chk("redir_stall_cnt", 32'(stall_count), 1);
    chk("redir_flush_cnt", 32'(flush_count), 1);

    // Multi-cycle op with mc_done arriving 5 cycles after the start. A
    // redirect raised while waiting must be ignored.
    cnt_clr = 1;
    next(); cnt_clr = 0; ex_mc_start = 1;
    st = 0; fl = 0; bz = 0; sel = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin next(); ex_mc_start = 0; end
      mc_done = (c == 5);
      ex_redirect = (c == 2);
      @(negedge clk);
      if (!pc_we) st++;
      if (ex_mem_flush) fl++;
      if (busy) bz++;
      if (pc_sel) sel++;
      if (c == 1) chk("mc_wait_ctl", 32'(ctl()), 32'(MCST));
      if (c == 5) chk("mc_done_ctl", 32'(ctl()), 32'(DEF));
    end
    next(); idle();
    chk("mc_stall_cycles", st, 5);
    chk("mc_exm_flush_cycles", fl, 5);
    chk("mc_busy_cycles", bz, 4);
    chk("mc_redirect_ignored", sel, 0);
    chk("mc_stall_cnt", 32'(stall_count), 5);
    chk("mc_flush_cnt", 32'(flush_count), 0);
    @(negedge clk);
    chk("mc_busy_after", 32'(busy), 0);

    // Watchdog: mc_done never arrives. The pulse must come exactly once, 64
    // cycles after the start. The stall count saturates at 15.
    next(); ex_mc_start = 1;
    pulses = 0; at = -1;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) begin next(); ex_mc_start = 0; end
      @(negedge clk);
      if (mc_timeout) begin
        pulses++; at = c;
        chk("wd_ctl", 32'(ctl()), 32'(WDOG));
      end
    end
    chk("wd_pulses", pulses, 1);
    chk("wd_cycle", at, MCM);
    chk("wd_busy", 32'(busy), 0);
    chk("wd_stall_sat", 32'(stall_count), 15);
    next(); load_use5();
    next(); idle();
    chk("sat_hold", 32'(stall_count), 15);
    load_use5(); cnt_clr = 1;
    next(); idle();
    chk("clr_over_inc", 32'(stall_count), 0);

    // Reset asserted mid-wait must abort immediately, without waiting for a clock edge.
    ex_mc_start = 1;
    next(); ex_mc_start = 0;
    next();
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    #1 rst = 0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_ctl", 32'(ctl()), 32'(DEF));
    chk("async_rst_stall_cnt", 32'(stall_count), 0);
    @(negedge clk); rst = 1;
    next();
    @(negedge clk);
    chk("post_rst_ctl", 32'(ctl()), 32'(DEF));
    chk("post_rst_busy", 32'(busy), 0);

    // One-cycle multi-cycle op: there is no stall and busy stays low.
    next(); ex_mc_start = 1; mc_done = 1;
    @(negedge clk);
    chk("mc1_ctl", 32'(ctl()), 32'(DEF));
    chk("mc1_busy", 32'(busy), 0);
    next(); idle();
    @(negedge clk);
    chk("mc1_busy_next", 32'(busy), 0);
    chk("mc1_stall_cnt", 32'(stall_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
